marker_bbox_tracker: RTL and testbench
======================================

Name: marker_bbox_tracker

Overview:
- Upstream stage of the game-logic block: scans the camera pixel stream for one frame and finds the four extreme points of the marker colour (leftmost, rightmost, topmost, bottommost).
- At frame end it presents those points as {x,y} pairs with a one-cycle predict-valid pulse.
- If the marker is absent, every coordinate is the sentinel 2023, which the game logic treats as "not found, extrapolate".

Parameters:
- CW, 11, coordinate width.
- H_ACTIVE, 800, pixels per line; pixels with x >= H_ACTIVE are ignored.
- V_ACTIVE, 600, lines per frame; pixels with y >= V_ACTIVE are ignored.
- R_MIN, 160, minimum red component for a match.
- G_MAX, 80, maximum green component for a match.
- B_MAX, 80, maximum blue component for a match.
- MIN_PIXELS, 16, matched pixels required per frame to report "found".
- SENTINEL, 2023, not-found coordinate value.

Ports:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_frame_start, in, 1, one-cycle pulse before the first pixel of a frame.
- i_frame_end, in, 1, one-cycle pulse at or after the last pixel of a frame.
- i_pix_valid, in, 1, pixel qualifier.
- i_x, in, CW, pixel column.
- i_y, in, CW, pixel row.
- i_rgb, in, 3x8, [0]=R, [1]=G, [2]=B.
- o_predict_valid, out, 1, one-cycle result pulse.
- o_left, out, 2xCW, [0]=x, [1]=y of the leftmost match.
- o_right, out, 2xCW, rightmost match.
- o_up, out, 2xCW, topmost match.
- o_down, out, 2xCW, bottommost match.
- o_pix_count, out, 20, matched-pixel count of the last reported frame.

Behaviour:
- Reset (asynchronous):
  - state = S_IDLE; o_predict_valid = 0.
  - All o_left/o_right/o_up/o_down fields = SENTINEL; o_pix_count = 0.
  - Accumulators cleared.
- Match rule: i_pix_valid && x < H_ACTIVE && y < V_ACTIVE && R >= R_MIN && G <= G_MAX && B <= B_MAX. All comparisons are unsigned.
- States:
  - S_IDLE: waits for i_frame_start, then goes to S_SCAN with accumulators cleared. i_frame_end is ignored.
  - S_SCAN: each matching pixel updates the accumulators on the next clock edge.
    - Left extreme updates on strictly smaller x; right on strictly greater x; up on strictly smaller y; down on strictly greater y.
    - Each update stores both x and y of that pixel.
    - Ties keep the earliest pixel in raster order.
    - The first match of a frame initialises all four extremes.
    - Count increments and saturates at 2^20-1.
  - S_SCAN, i_frame_end sampled:
    - A pixel presented in the same cycle is included.
    - Next edge: outputs are loaded, o_predict_valid = 1 for exactly one cycle, and the block moves to S_REPORT.
  - S_REPORT: one cycle, then S_IDLE. If i_frame_start arrives during S_REPORT, the block goes directly to S_SCAN with cleared accumulators.
- Result loading:
  - count >= MIN_PIXELS: load the extremes and o_pix_count = count.
  - Otherwise: all coordinates = SENTINEL and o_pix_count = count.
- Latency: o_predict_valid rises exactly 1 cycle after i_frame_end is sampled.
- Outputs hold their values until the next report.
- i_frame_start while in S_SCAN: the current frame is aborted with no report; accumulators are cleared and the block stays in S_SCAN.
- i_frame_start and i_frame_end in the same cycle in S_SCAN: the current frame is reported, accumulators are cleared, and the next state is S_SCAN (the new frame begins). The pixel in that cycle belongs to the reported frame.
- Non-matching pixels and cycles with i_pix_valid = 0 change nothing.

Optional Feature:
- Macro: MARKER_RUN_FILTER_EN.
- Defined: a pixel counts only if the previous valid pixel had the same y, x equal to current x-1, and also matched (horizontal run >= 2).
  - The first pixel of each run is discarded; the second and later pixels use their own coordinates.
  - The run register clears on a non-match, a row change, a column gap, reset, or i_frame_start.
- Undefined: every matching pixel counts, and no run register exists.

Decomposition:
- game_pkg:
  - localparams: CW, SENTINEL.
  - typedef coord_t, logic [CW-1:0].
  - typedef point_t, coord_t [1:0].
  - typedef enum tracker_state_t {S_IDLE, S_SCAN, S_REPORT}.
  - Shared with the game logic.
- Sub-module marker_color_match: purely combinational. Inputs rgb, x, y, valid; output match. It is reused by the debug overlay.

Test Plan:
- Empty frame: start, 800x600 black pixels, end → one pulse; all coordinates 2023; o_pix_count = 0.
- 10x10 red square at (100..109, 200..209):
  - Pulse 1 cycle after end.
  - left = (100,200), right = (109,200), up = (100,200), down = (100,209).
  - o_pix_count = 100.
- 15 scattered matches (< MIN_PIXELS): all coordinates 2023, o_pix_count = 15. Then 16 matches → real coordinates reported.
- Boundary and priority cases:
  - Red pixel at x = 800 is ignored.
  - Pixel with G = 81 does not match.
  - Last matching pixel presented with i_frame_end is included in the result.
- Abort and reset:
  - i_frame_start mid-scan → no pulse; only the next frame is reported.
  - i_rst_n low mid-scan → all outputs revert to 2023/0 immediately.
- MARKER_RUN_FILTER_EN: isolated red pixels at (50,50) and (300,300) plus a 1x20 run at y = 400, x = 10..29.
  - Filter defined: count = 19, left = (11,400).
  - Filter undefined: count = 22, left = (10,400), up = (50,50).

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-logic types: coordinate width, not-found sentinel, point and tracker state types.
package game_pkg;

  localparam int CW = 11;

  typedef logic [CW-1:0] coord_t;
  // Packed pair: [0] = x, [1] = y
  typedef coord_t [1:0] point_t;

  localparam coord_t SENTINEL = 11'd2023;
  localparam point_t NOT_FOUND = {SENTINEL, SENTINEL};
  localparam logic [19:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_REPORT = 2'd2
  } tracker_state_t;

  function automatic point_t make_point(input coord_t x, input coord_t y);
    return {y, x};
  endfunction

endpackage

// File: rtl/marker_bbox_tracker_color_match.sv
// Combinational marker-colour classifier; also reused by the debug overlay.
module marker_color_match
  import game_pkg::*;
#(
  parameter logic [CW-1:0] H_ACTIVE = 11'd800,
  parameter logic [CW-1:0] V_ACTIVE = 11'd600,
  parameter logic [7:0]    R_MIN    = 8'd160,
  parameter logic [7:0]    G_MAX    = 8'd80,
  parameter logic [7:0]    B_MAX    = 8'd80
) (
  input  logic [2:0][7:0]  rgb,
  input  logic [CW-1:0]    x,
  input  logic [CW-1:0]    y,
  input  logic             valid,
  output logic             match
);

  assign match = valid
               && (x < H_ACTIVE) && (y < V_ACTIVE)
               && (rgb[0] >= R_MIN)
               && (rgb[1] <= G_MAX)
               && (rgb[2] <= B_MAX);

endmodule

// File: rtl/marker_bbox_tracker.sv
// Per-frame extreme-point tracker for the marker colour; reports {x,y} extremes at frame end.
// Optional horizontal-run filter: define MARKER_RUN_FILTER_EN.
module marker_bbox_tracker
  import game_pkg::*;
#(
  parameter logic [CW-1:0] H_ACTIVE   = 11'd800,
  parameter logic [CW-1:0] V_ACTIVE   = 11'd600,
  parameter logic [7:0]    R_MIN      = 8'd160,
  parameter logic [7:0]    G_MAX      = 8'd80,
  parameter logic [7:0]    B_MAX      = 8'd80,
  parameter logic [19:0]   MIN_PIXELS = 20'd16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_frame_start,
  input  logic            i_frame_end,
  input  logic            i_pix_valid,
  input  logic [CW-1:0]   i_x,
  input  logic [CW-1:0]   i_y,
  input  logic [2:0][7:0] i_rgb,
  output logic            o_predict_valid,
  output point_t          o_left,
  output point_t          o_right,
  output point_t          o_up,
  output point_t          o_down,
  output logic [19:0]     o_pix_count
);

  tracker_state_t state;

  logic        color_match;
  logic        hit;
  logic        found;
  point_t      cur;
  logic [19:0] count, count_nxt;
  point_t      left, right, up, down;
  point_t      left_nxt, right_nxt, up_nxt, down_nxt;

  marker_color_match #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .R_MIN    (R_MIN),
    .G_MAX    (G_MAX),
    .B_MAX    (B_MAX)
  ) u_match (
    .rgb   (i_rgb),
    .x     (i_x),
    .y     (i_y),
    .valid (i_pix_valid),
    .match (color_match)
  );

  assign cur = make_point(i_x, i_y);

`ifdef MARKER_RUN_FILTER_EN
  // Remembers the last valid pixel; a pixel counts only when it extends a matched run by one column.
  logic          run_active;
  logic [CW-1:0] run_x, run_y;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_active <= 1'b0;
      run_x      <= '0;
      run_y      <= '0;
    end else if (i_frame_start) begin
      run_active <= 1'b0;
    end else if (i_pix_valid) begin
      run_active <= color_match;
      run_x      <= i_x;
      run_y      <= i_y;
    end
  end

  assign hit = color_match && run_active && (run_y == i_y) && ((run_x + 1'b1) == i_x);
`else
  assign hit = color_match;
`endif

  // Accumulator view including this cycle's pixel, so a pixel arriving with i_frame_end is reported.
  always_comb begin
    count_nxt = count;
    left_nxt  = left;
    right_nxt = right;
    up_nxt    = up;
    down_nxt  = down;
    if (state == S_SCAN && hit) begin
      if (count != COUNT_MAX) count_nxt = count + 20'd1;
      if (count == '0) begin
        left_nxt  = cur;
        right_nxt = cur;
        up_nxt    = cur;
        down_nxt  = cur;
      end else begin
        if (i_x < left[0])  left_nxt  = cur;
        if (i_x > right[0]) right_nxt = cur;
        if (i_y < up[1])    up_nxt    = cur;
        if (i_y > down[1])  down_nxt  = cur;
      end
    end
  end

  assign found = (count_nxt >= MIN_PIXELS);

  // i_frame_start clears the accumulators in every state, overriding the update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
      left  <= '0;
      right <= '0;
      up    <= '0;
      down  <= '0;
    end else if (i_frame_start) begin
      count <= '0;
      left  <= '0;
      right <= '0;
      up    <= '0;
      down  <= '0;
    end else begin
      count <= count_nxt;
      left  <= left_nxt;
      right <= right_nxt;
      up    <= up_nxt;
      down  <= down_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      o_predict_valid <= 1'b0;
      o_left          <= NOT_FOUND;
      o_right         <= NOT_FOUND;
      o_up            <= NOT_FOUND;
      o_down          <= NOT_FOUND;
      o_pix_count     <= '0;
    end else begin
      o_predict_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_frame_start) state <= S_SCAN;
        end
        S_SCAN: begin
          if (i_frame_end) begin
            o_predict_valid <= 1'b1;
            o_pix_count     <= count_nxt;
            o_left          <= found ? left_nxt  : NOT_FOUND;
            o_right         <= found ? right_nxt : NOT_FOUND;
            o_up            <= found ? up_nxt    : NOT_FOUND;
            o_down          <= found ? down_nxt  : NOT_FOUND;
          end
          if (i_frame_start)    state <= S_SCAN;
          else if (i_frame_end) state <= S_REPORT;
        end
        S_REPORT: begin
          state <= i_frame_start ? S_SCAN : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_marker_bbox_tracker.sv
// Directed self-checking bench for marker_bbox_tracker; expectations follow MARKER_RUN_FILTER_EN.
module tb_marker_bbox_tracker;

  logic            i_clk;
  logic            i_rst_n;
  logic            i_frame_start;
  logic            i_frame_end;
  logic            i_pix_valid;
  logic [10:0]     i_x;
  logic [10:0]     i_y;
  logic [2:0][7:0] i_rgb;
  logic            o_predict_valid;
  logic [21:0]     o_left, o_right, o_up, o_down;
  logic [19:0]     o_pix_count;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  localparam logic [21:0] NF = {11'd2023, 11'd2023};

  logic [107:0] got, exp;

  marker_bbox_tracker dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_frame_start   (i_frame_start),
    .i_frame_end     (i_frame_end),
    .i_pix_valid     (i_pix_valid),
    .i_x             (i_x),
    .i_y             (i_y),
    .i_rgb           (i_rgb),
    .o_predict_valid (o_predict_valid),
    .o_left          (o_left),
    .o_right         (o_right),
    .o_up            (o_up),
    .o_down          (o_down),
    .o_pix_count     (o_pix_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_predict_valid === 1'b1) pulses++;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  function automatic logic [21:0] pt(input int x, input int y);
    logic [10:0] xs, ys;
    xs = x[10:0];
    ys = y[10:0];
    return {ys, xs};
  endfunction

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic v, input logic fs, input logic fe);
    i_pix_valid   = v;
    i_x           = x[10:0];
    i_y           = y[10:0];
    i_rgb[0]      = r;
    i_rgb[1]      = g;
    i_rgb[2]      = b;
    i_frame_start = fs;
    i_frame_end   = fe;
    cyc();
    i_pix_valid   = 1'b0;
    i_frame_start = 1'b0;
    i_frame_end   = 1'b0;
  endtask

  task automatic red(input int x, input int y);
    drive(x, y, 8'd200, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic frame_start();
    drive(0, 0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic frame_end();
    drive(0, 0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_frame_start = 1'b0; i_frame_end = 1'b0; i_pix_valid = 1'b0;
    i_x = '0; i_y = '0; i_rgb = '0;
    repeat (3) cyc();
    checks++;
    if (o_predict_valid !== 1'b0) begin
      errors++; $display("FAIL reset_pulse: got %b expected 0", o_predict_valid);
    end
    got = {o_left, o_right, o_up, o_down, o_pix_count};
    exp = {NF, NF, NF, NF, 20'd0};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", got, exp);
    end
    i_rst_n = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic test_empty_frame();
    frame_start();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 800; x++)
        drive(x, y, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    drive(5, 5, 8'd200, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    frame_end();
    checks++;
    if (o_predict_valid !== 1'b1) begin
      errors++; $display("FAIL empty_pulse: got %b expected 1", o_predict_valid);
    end
    cyc();
    checks++;
    if (o_predict_valid !== 1'b0) begin
      errors++; $display("FAIL empty_pulse_width: got %b expected 0", o_predict_valid);
    end
    got = {o_left, o_right, o_up, o_down, o_pix_count};
    exp = {NF, NF, NF, NF, 20'd0};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL empty_outputs: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_square();
    frame_start();
    for (int y = 200; y < 210; y++) begin
      for (int x = 100; x < 110; x++) red(x, y);
      drive(110, y, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    end
    frame_end();
    checks++;
    if (o_predict_valid !== 1'b1) begin
      errors++; $display("FAIL square_pulse: got %b expected 1", o_predict_valid);
    end
`ifdef MARKER_RUN_FILTER_EN
    exp = {pt(101,200), pt(109,200), pt(101,200), pt(101,209), 20'd90};
`else
    exp = {pt(100,200), pt(109,200), pt(100,200), pt(100,209), 20'd100};
`endif
    got = {o_left, o_right, o_up, o_down, o_pix_count};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL square_outputs: got %h expected %h", got, exp);
    end
    repeat (3) cyc();
    got = {o_left, o_right, o_up, o_down, o_pix_count};
    checks++;
    if (got !== exp || o_predict_valid !== 1'b0) begin
      errors++; $display("FAIL square_hold: got %h/%b expected %h/0", got, o_predict_valid, exp);
    end
  endtask

  task automatic test_min_pixels();
    frame_start();
    for (int i = 0; i < 15; i++) red(5 + 20*i, 3 + 10*i);
    frame_end();
    cyc();
`ifdef MARKER_RUN_FILTER_EN
    exp = {NF, NF, NF, NF, 20'd0};
`else
    exp = {NF, NF, NF, NF, 20'd15};
`endif
    got = {o_left, o_right, o_up, o_down, o_pix_count};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL below_min: got %h expected %h", got, exp);
    end
    frame_start();
    for (int i = 0; i < 16; i++) red(5 + 20*i, 3 + 10*i);
    frame_end();
    cyc();
`ifdef MARKER_RUN_FILTER_EN
    exp = {NF, NF, NF, NF, 20'd0};
`else
    exp = {pt(5,3), pt(305,153), pt(5,3), pt(305,153), 20'd16};
`endif
    got = {o_left, o_right, o_up, o_down, o_pix_count};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL at_min: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_boundary();
    frame_start();
    red(800, 5);
    red(50, 600);
    for (int x = 100; x < 116; x++) red(x, 10);
    drive(2, 20, 8'd200, 8'd81, 8'd0, 1'b1, 1'b0, 1'b0);
    red(700, 30);
    drive(701, 30, 8'd200, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (o_predict_valid !== 1'b1) begin
      errors++; $display("FAIL boundary_pulse: got %b expected 1", o_predict_valid);
    end
`ifdef MARKER_RUN_FILTER_EN
    exp = {pt(101,10), pt(701,30), pt(101,10), pt(701,30), 20'd16};
`else
    exp = {pt(100,10), pt(701,30), pt(100,10), pt(700,30), 20'd18};
`endif
    got = {o_left, o_right, o_up, o_down, o_pix_count};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL boundary_outputs: got %h expected %h", got, exp);
    end
    cyc();
  endtask

  task automatic test_abort();
    int p0;
    frame_start();
    for (int x = 0; x < 20; x++) red(x, 50);
    p0 = pulses;
    frame_start();
    for (int x = 300; x < 317; x++) red(x, 60);
    repeat (2) cyc();
    checks++;
    if (pulses != p0) begin
      errors++; $display("FAIL abort_no_pulse: got %0d pulses expected %0d", pulses, p0);
    end
    frame_end();
    checks++;
    if (o_predict_valid !== 1'b1) begin
      errors++; $display("FAIL abort_next_pulse: got %b expected 1", o_predict_valid);
    end
`ifdef MARKER_RUN_FILTER_EN
    exp = {pt(301,60), pt(316,60), pt(301,60), pt(301,60), 20'd16};
`else
    exp = {pt(300,60), pt(316,60), pt(300,60), pt(300,60), 20'd17};
`endif
    got = {o_left, o_right, o_up, o_down, o_pix_count};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL abort_outputs: got %h expected %h", got, exp);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    frame_start();
    for (int x = 400; x < 416; x++) red(x, 70);
    drive(416, 70, 8'd200, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (o_predict_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_pulse1: got %b expected 1", o_predict_valid);
    end
`ifdef MARKER_RUN_FILTER_EN
    exp = {pt(401,70), pt(416,70), pt(401,70), pt(401,70), 20'd16};
`else
    exp = {pt(400,70), pt(416,70), pt(400,70), pt(400,70), 20'd17};
`endif
    got = {o_left, o_right, o_up, o_down, o_pix_count};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL b2b_outputs1: got %h expected %h", got, exp);
    end
    for (int x = 10; x < 27; x++) red(x, 80);
    frame_end();
    checks++;
    if (o_predict_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_pulse2: got %b expected 1", o_predict_valid);
    end
`ifdef MARKER_RUN_FILTER_EN
    exp = {pt(11,80), pt(26,80), pt(11,80), pt(11,80), 20'd16};
`else
    exp = {pt(10,80), pt(26,80), pt(10,80), pt(10,80), 20'd17};
`endif
    got = {o_left, o_right, o_up, o_down, o_pix_count};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL b2b_outputs2: got %h expected %h", got, exp);
    end
    cyc();
  endtask

  task automatic test_run_filter();
    frame_start();
    red(50, 50);
    red(300, 300);
    for (int x = 10; x < 30; x++) red(x, 400);
    frame_end();
`ifdef MARKER_RUN_FILTER_EN
    exp = {pt(11,400), pt(29,400), pt(11,400), pt(11,400), 20'd19};
`else
    exp = {pt(10,400), pt(300,300), pt(50,50), pt(10,400), 20'd22};
`endif
    got = {o_left, o_right, o_up, o_down, o_pix_count};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL run_filter_outputs: got %h expected %h", got, exp);
    end
    cyc();
  endtask

  task automatic test_reset_mid_scan();
    int p0;
    frame_start();
    for (int x = 0; x < 5; x++) red(x, 90);
    #2 i_rst_n = 1'b0;
    #1;
    got = {o_left, o_right, o_up, o_down, o_pix_count};
    exp = {NF, NF, NF, NF, 20'd0};
    checks++;
    if (got !== exp || o_predict_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_scan: got %h/%b expected %h/0", got, o_predict_valid, exp);
    end
    #1 i_rst_n = 1'b1;
    cyc();
    p0 = pulses;
    frame_end();
    repeat (2) cyc();
    checks++;
    if (pulses != p0) begin
      errors++; $display("FAIL idle_end_ignored: got %0d pulses expected %0d", pulses, p0);
    end
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_square();
    test_min_pixels();
    test_boundary();
    test_abort();
    test_back_to_back();
    test_run_filter();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
